fp_mult_result_checker: RTL and testbench
=========================================

// Module: fp_mult_result_checker
// PURPOSE
// Self-checking stage directly downstream of the registered FP32 multiplier wrapper.
// Consumes the wrapper's registered result z, its reference result z_function_out and
// its 8-bit status. Tracks operand validity through the wrapper's fixed pipeline
// latency, compares DUT against reference, counts samples and mismatches,
// OR-accumulates status flags, and logs the first mismatching transaction.
// PARAMETERS
// LAT        2  cycles from a/b at wrapper input to z/z_ref/status at wrapper output
// CNT_W      16 width of sample and mismatch counters (saturating)
// NAN_EQUIV  1  1: any NaN vs any NaN counts as match; 0: bit-exact compare only
// HALT_ON_MM 0  1: first mismatch ends the run (DONE, halted=1)
// PORTS
// clk          in  1      clock, all state on rising edge
// rst          in  1      asynchronous, active-low reset
// start        in  1      pulse: clear results and begin a run (sampled in IDLE/DONE only)
// stop         in  1      pulse: end of stimulus; drain pipeline then finish
// in_valid     in  1      a/b valid this cycle, aligned with wrapper inputs a/b
// a, b         in  32     operands driven to the wrapper this cycle
// z            in  32     wrapper result
// z_ref        in  32     wrapper reference result (z_function_out)
// status       in  8      wrapper status flags
// busy         out 1      1 in RUN or DRAIN
// done         out 1      1 in DONE
// halted       out 1      run ended by HALT_ON_MM
// sample_cnt   out CNT_W  compared samples
// mismatch_cnt out CNT_W  mismatching samples
// status_acc   out 8      OR of status over all compared samples
// mm_valid     out 1      first-mismatch log is populated
// mm_a, mm_b   out 32     operands of first mismatch
// mm_z, mm_ref out 32     DUT and reference results of first mismatch
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; every output 0; delay line valid bits 0.
// - States: IDLE, RUN, DRAIN, DONE.
//   IDLE/DONE --start--> RUN: counters, status_acc, mm_*, halted, delay line cleared.
//   RUN --stop--> DRAIN; DRAIN lasts exactly LAT cycles --> DONE.
//   RUN/DRAIN --mismatch with HALT_ON_MM=1--> DONE, halted=1, same cycle the mismatch is counted.
//   start ignored in RUN/DRAIN; stop ignored outside RUN. start+stop together in IDLE: start wins.
// - Delay line: LAT-deep shift of {in_valid,a,b}; in_valid enters only in RUN
//   (including the cycle stop is sampled); in_valid in IDLE/DRAIN/DONE is dropped.
// - Sample at output of delay line with valid=1 and state RUN or DRAIN:
//   match = (z==z_ref) | (NAN_EQUIV & isnan(z) & isnan(z_ref));
//   isnan(x) = x[30:23]==8'hFF && x[22:0]!=0.
//   sample_cnt+1; if !match mismatch_cnt+1; status_acc |= status. Updates visible next cycle.
// - Counters saturate at all-ones; no wrap.
// - First mismatch only: mm_a/mm_b from delay line, mm_z=z, mm_ref=z_ref, mm_valid=1; later
//   mismatches do not overwrite.
// - Outputs hold in DONE until next start or reset. Reset mid-run aborts; no partial results kept.
// TESTING
// - start; in_valid a=40000000 b=40400000; z=z_ref=40C00000 after LAT; stop -> sample_cnt=1, mismatch_cnt=0, done after LAT DRAIN cycles.
// - Same op with z=40C00001, z_ref=40C00000 -> mismatch_cnt=1, mm_valid=1, mm_a=40000000, mm_b=40400000, mm_z=40C00001.
// - z=7FC00000 z_ref=7FC00001: NAN_EQUIV=1 -> mismatch_cnt=0; NAN_EQUIV=0 -> mismatch_cnt=1.
// - CNT_W=4, 20 valid matching samples -> sample_cnt=4'hF; status 01 then 20 -> status_acc=8'h21.
// - HALT_ON_MM=1, 5 samples, 3rd mismatches -> done, halted=1, sample_cnt=3, later samples ignored.
// - rst low mid-RUN after 3 samples -> all outputs 0 asynchronously, state IDLE, in-flight samples lost.

Source files
------------

// File: rtl/fp_mult_result_checker.sv
// fp_mult_result_checker: compares FP32 multiplier results against reference through the wrapper latency, counting and logging mismatches
// Ports: clk; rst (async, active-low); start/stop run control; in_valid/a/b wrapper operands;
// z/z_ref/status wrapper outputs; busy/done/halted run state; sample_cnt/mismatch_cnt saturating
// counters; status_acc OR of sampled status; mm_valid/mm_a/mm_b/mm_z/mm_ref first-mismatch log.
module fp_mult_result_checker #(
  parameter int LAT = 2,
  parameter int CNT_W = 16,
  parameter bit NAN_EQUIV = 1'b1,
  parameter bit HALT_ON_MM = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [31:0]      z,
  input  logic [31:0]      z_ref,
  input  logic [7:0]       status,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [7:0]       status_acc,
  output logic             mm_valid,
  output logic [31:0]      mm_a,
  output logic [31:0]      mm_b,
  output logic [31:0]      mm_z,
  output logic [31:0]      mm_ref
);
  localparam int DW = $clog2(LAT + 1);
  localparam int W = 32 * LAT;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [LAT-1:0] dv;
  logic [W-1:0] da, db;
  logic [DW-1:0] dc;
  logic go, act, smp, match, mm, halt;
  always_comb begin
    go = start && (state == IDLE || state == DONE);
    act = state == RUN || state == DRAIN;
    smp = dv[LAT-1] && act;
    match = z == z_ref || (NAN_EQUIV && z[30:23] == 8'hFF && z[22:0] != 23'd0 &&
                           z_ref[30:23] == 8'hFF && z_ref[22:0] != 23'd0);
    mm = smp && !match;
    halt = HALT_ON_MM && mm;
    nxt = go ? RUN : !act ? state : halt ? DONE : state == RUN ? (stop ? DRAIN : RUN) :
          dc == DW'(LAT - 1) ? DONE : DRAIN;
  end
  assign busy = act;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dc <= '0;
      dv <= '0;
      da <= '0;
      db <= '0;
      halted <= 1'b0;
      sample_cnt <= '0;
      mismatch_cnt <= '0;
      status_acc <= '0;
      mm_valid <= 1'b0;
      mm_a <= '0;
      mm_b <= '0;
      mm_z <= '0;
      mm_ref <= '0;
    end else begin
      dc <= state == DRAIN ? dc + DW'(1) : '0;
      if (go) begin
        dv <= '0;
        da <= '0;
        db <= '0;
        halted <= 1'b0;
        sample_cnt <= '0;
        mismatch_cnt <= '0;
        status_acc <= '0;
        mm_valid <= 1'b0;
        mm_a <= '0;
        mm_b <= '0;
        mm_z <= '0;
        mm_ref <= '0;
      end else begin
        dv <= LAT'({dv, in_valid && state == RUN});
        da <= W'({da, a});
        db <= W'({db, b});
        if (smp && ~&sample_cnt) sample_cnt <= sample_cnt + CNT_W'(1);
        if (mm && ~&mismatch_cnt) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        if (smp) status_acc <= status_acc | status;
        if (mm && !mm_valid) begin
          mm_valid <= 1'b1;
          mm_a <= da[W-1 -: 32];
          mm_b <= db[W-1 -: 32];
          mm_z <= z;
          mm_ref <= z_ref;
        end
        if (halt) halted <= 1'b1;
      end
    end
endmodule

// File: tb/tb_fp_mult_result_checker.sv
// tb_fp_mult_result_checker: three checker configurations driven in parallel against a scoreboard model
module tb_fp_mult_result_checker;
  localparam int LAT = 2;
  typedef struct {
    bit v;
    logic [31:0] a, b, z, zr;
    logic [7:0] st;
    bit mm1, mm0;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, start, stop, in_valid;
  logic [31:0] a, b, z, z_ref;
  logic [7:0] status;
  logic [2:0] o_busy, o_done, o_halt, o_mmv;
  logic [2:0][7:0] o_acc;
  logic [2:0][31:0] o_ma, o_mb, o_mz, o_mr;
  logic [15:0] sc0, mc0, sc2, mc2;
  logic [3:0] sc1, mc1;
  int tests = 0, fails = 0;
  vec_t vt[9];
  vec_t nv;
  vec_t pq[$];
  int ms[3], mdc[3], msc[3], mmc[3];
  bit mh[3], mmv[3];
  logic [7:0] macc[3];
  logic [31:0] mma[3], mmb[3], mmz[3], mmr[3];

  always #5 clk = ~clk;

  fp_mult_result_checker #(.LAT(LAT)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .a(a), .b(b),
    .z(z), .z_ref(z_ref), .status(status), .busy(o_busy[0]), .done(o_done[0]),
    .halted(o_halt[0]), .sample_cnt(sc0), .mismatch_cnt(mc0), .status_acc(o_acc[0]),
    .mm_valid(o_mmv[0]), .mm_a(o_ma[0]), .mm_b(o_mb[0]), .mm_z(o_mz[0]), .mm_ref(o_mr[0]));
  fp_mult_result_checker #(.LAT(LAT), .CNT_W(4), .NAN_EQUIV(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .a(a), .b(b),
    .z(z), .z_ref(z_ref), .status(status), .busy(o_busy[1]), .done(o_done[1]),
    .halted(o_halt[1]), .sample_cnt(sc1), .mismatch_cnt(mc1), .status_acc(o_acc[1]),
    .mm_valid(o_mmv[1]), .mm_a(o_ma[1]), .mm_b(o_mb[1]), .mm_z(o_mz[1]), .mm_ref(o_mr[1]));
  fp_mult_result_checker #(.LAT(LAT), .HALT_ON_MM(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .a(a), .b(b),
    .z(z), .z_ref(z_ref), .status(status), .busy(o_busy[2]), .done(o_done[2]),
    .halted(o_halt[2]), .sample_cnt(sc2), .mismatch_cnt(mc2), .status_acc(o_acc[2]),
    .mm_valid(o_mmv[2]), .mm_a(o_ma[2]), .mm_b(o_mb[2]), .mm_z(o_mz[2]), .mm_ref(o_mr[2]));

  task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s u%0d: got %h expected %h at %0t", n, k, act, exp, $time);
    end
  endtask

  task automatic clr(input int k);
    mdc[k] = 0; msc[k] = 0; mmc[k] = 0; mh[k] = 0; mmv[k] = 0; macc[k] = 0;
    mma[k] = 0; mmb[k] = 0; mmz[k] = 0; mmr[k] = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      clr(k);
      ms[k] = 0;
    end
    pq.delete();
    repeat (LAT) pq.push_back(nv);
  endtask

  task automatic model(input int k, input bit s, input bit p, input vec_t e);
    bit smp, mmx;
    int mx;
    mx = (k == 1) ? 15 : 65535;
    if (s && (ms[k] == 0 || ms[k] == 3)) begin
      clr(k);
      ms[k] = 1;
    end else begin
      smp = e.v && (ms[k] == 1 || ms[k] == 2);
      mmx = smp && ((k == 1) ? e.mm0 : e.mm1);
      if (smp) begin
        if (msc[k] < mx) msc[k]++;
        if (mmx && mmc[k] < mx) mmc[k]++;
        macc[k] |= e.st;
        if (mmx && !mmv[k]) begin
          mmv[k] = 1; mma[k] = e.a; mmb[k] = e.b; mmz[k] = e.z; mmr[k] = e.zr;
        end
      end
      if (k == 2 && mmx) begin
        ms[k] = 3;
        mh[k] = 1;
      end else if (ms[k] == 1 && p) begin
        ms[k] = 2;
        mdc[k] = 0;
      end else if (ms[k] == 2) begin
        if (mdc[k] == LAT - 1) ms[k] = 3;
        else mdc[k]++;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [15:0] sc, mc;
      sc = (k == 0) ? sc0 : (k == 1) ? {12'h0, sc1} : sc2;
      mc = (k == 0) ? mc0 : (k == 1) ? {12'h0, mc1} : mc2;
      chk("busy", k, 32'(o_busy[k]), 32'(ms[k] == 1 || ms[k] == 2));
      chk("done", k, 32'(o_done[k]), 32'(ms[k] == 3));
      chk("halted", k, 32'(o_halt[k]), 32'(mh[k]));
      chk("sample_cnt", k, 32'(sc), msc[k]);
      chk("mismatch_cnt", k, 32'(mc), mmc[k]);
      chk("status_acc", k, 32'(o_acc[k]), 32'(macc[k]));
      chk("mm_valid", k, 32'(o_mmv[k]), 32'(mmv[k]));
      chk("mm_a", k, o_ma[k], mma[k]);
      chk("mm_b", k, o_mb[k], mmb[k]);
      chk("mm_z", k, o_mz[k], mmz[k]);
      chk("mm_ref", k, o_mr[k], mmr[k]);
    end
  endtask

  // one clock: drive at negedge, scoreboard plays the wrapper by replaying results LAT cycles later
  task automatic cyc(input bit s, input bit v, input bit p, input int i);
    vec_t x, e;
    x = nv;
    if (i >= 0) x = vt[i];
    e = nv;
    @(negedge clk);
    start = s; stop = p; in_valid = v; a = x.a; b = x.b;
    if (s && (ms[0] == 0 || ms[0] == 3)) begin
      pq.delete();
      repeat (LAT) pq.push_back(nv);
    end else begin
      x.v = v && ms[0] == 1;
      pq.push_back(x);
      e = pq.pop_front();
    end
    z = e.v ? e.z : 32'hDEAD0000;
    z_ref = e.v ? e.zr : 32'hBEEF0000;
    status = e.v ? e.st : 8'h80;
    for (int k = 0; k < 3; k++) model(k, s, p, e);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drain();
    repeat (LAT) cyc(0, 0, 0, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nv = '{default: '0};
    vt[0] = '{1'b1, 32'h40000000, 32'h40400000, 32'h40C00000, 32'h40C00000, 8'h01, 1'b0, 1'b0};
    vt[1] = '{1'b1, 32'h40000000, 32'h40400000, 32'h40C00001, 32'h40C00000, 8'h00, 1'b1, 1'b1};
    vt[2] = '{1'b1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00001, 8'h20, 1'b0, 1'b1};
    vt[3] = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 8'h00, 1'b0, 1'b0};
    vt[4] = '{1'b1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h7FC00000, 8'h04, 1'b1, 1'b1};
    vt[5] = '{1'b1, 32'hC0000000, 32'h40000000, 32'hC0800000, 32'hC0800000, 8'h00, 1'b0, 1'b0};
    vt[6] = '{1'b1, 32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000, 8'h00, 1'b1, 1'b1};
    vt[7] = '{1'b1, 32'h7FFFFFFF, 32'h3F800000, 32'h7FFFFFFF, 32'hFFC00000, 8'h10, 1'b0, 1'b1};
    vt[8] = '{1'b1, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000, 8'h20, 1'b0, 1'b0};
    start = 0; stop = 0; in_valid = 0; a = 0; b = 0; z = 0; z_ref = 0; status = 0;
    #2 rst = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1;
    cyc(0, 0, 1, -1);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, i);
    cyc(0, 1, 1, 8);
    repeat (LAT + 2) cyc(0, 1, 0, 1);
    chk("r1_samples", 0, 32'(sc0), 32'd9);
    chk("r1_mismatch", 0, 32'(mc0), 32'd3);
    chk("r1_mismatch_bitexact", 1, 32'(mc1), 32'd5);
    chk("r1_status_acc", 0, 32'(o_acc[0]), 32'h35);
    chk("r1_mm_z", 0, o_mz[0], 32'h40C00001);
    chk("r1_halt_samples", 2, 32'(sc2), 32'd2);
    cyc(1, 0, 0, -1);
    for (int i = 0; i < 24; i++) cyc(i == 7, i % 6 != 5, 0, (i < 12) ? 0 : 8);
    cyc(0, 0, 1, -1);
    drain();
    chk("r2_sat", 1, 32'(sc1), 32'hF);
    chk("r2_status_acc", 1, 32'(o_acc[1]), 32'h21);
    chk("r2_samples", 0, 32'(sc0), 32'd20);
    cyc(1, 0, 0, -1);
    for (int i = 0; i < 18; i++) cyc(0, i != 8, 0, 1);
    cyc(0, 0, 1, -1);
    drain();
    chk("r3_mismatch", 0, 32'(mc0), 32'd17);
    chk("r3_mismatch_sat", 1, 32'(mc1), 32'hF);
    cyc(1, 0, 0, -1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 3);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 5);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, -1);
    drain();
    chk("r4_halt_samples", 2, 32'(sc2), 32'd3);
    chk("r4_halted", 2, 32'(o_halt[2]), 32'd1);
    chk("r4_samples", 0, 32'(sc0), 32'd5);
    cyc(1, 0, 0, -1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, -1);
    chk("r5_pre_reset", 0, 32'(sc0), 32'd3);
    @(negedge clk);
    #2 rst = 0;
    #1;
    model_reset();
    check_all();
    chk("r5_reset_busy", 0, 32'(o_busy[0]), 32'd0);
    @(negedge clk);
    rst = 1;
    cyc(1, 0, 0, -1);
    cyc(0, 1, 1, 2);
    cyc(0, 0, 0, -1);
    chk("r6_drain_busy", 0, 32'(o_done[0]), 32'd0);
    cyc(0, 0, 0, -1);
    chk("r6_done", 0, 32'(o_done[0]), 32'd1);
    chk("r6_nan_equiv", 0, 32'(mc0), 32'd0);
    chk("r6_nan_bitexact", 1, 32'(mc1), 32'd1);
    chk("r6_samples", 0, 32'(sc0), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
